// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit DRFA datapath: owns the PC and
// drives every register-bank, immediate and ALU control with registered outputs.
module control_sequencer #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_run,
    input  logic [15:0]         in_instruction,
    input  logic                in_zero_flag,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                out_mem_read_en,
    output logic                out_read_en,
    output logic                out_write_en,
    output logic [2:0]          out_rx_selector,
    output logic [2:0]          out_ry_selector,
    output logic                out_indirect_mode_en,
    output logic                out_alu_en,
    output logic                out_alu_op,
    output logic                out_imm_en,
    output logic [7:0]          out_imm_data,
    output logic                out_halted,
    output logic                out_illegal
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_WAIT    = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_MOV   = 5'b00001;
    localparam logic [4:0] OP_LDI   = 5'b00010;
    localparam logic [4:0] OP_LDIND = 5'b00011;
    localparam logic [4:0] OP_ADD   = 5'b00100;
    localparam logic [4:0] OP_SUB   = 5'b00101;
    localparam logic [4:0] OP_JMP   = 5'b00110;
    localparam logic [4:0] OP_JZ    = 5'b00111;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  ind_en_q, ind_en_d;
    logic                  alu_en_q, alu_en_d;
    logic                  alu_op_q, alu_op_d;
    logic                  imm_en_q, imm_en_d;
    logic                  illegal_q, illegal_d;
    logic                  halted_q, halted_d;

    logic [4:0]            opcode_s;
    logic [PC_WIDTH-1:0]   jump_target_s;
    logic [PC_WIDTH-1:0]   pc_inc_s;

    assign opcode_s      = ir_q[15:11];
    assign jump_target_s = PC_WIDTH'(ir_q[7:0]);
    assign pc_inc_s      = pc_q + PC_WIDTH'(1'b1);

    // Next-state and next-output logic; every output is the registered value of its _d.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mem_rd_d  = 1'b0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        ind_en_d  = 1'b0;
        alu_en_d  = 1'b0;
        alu_op_d  = 1'b0;
        imm_en_d  = 1'b0;
        illegal_d = 1'b0;
        halted_d  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // The read strobe is already on the bus this cycle; data follows next cycle.
                if (mem_rd_q) begin
                    state_d = ST_WAIT;
                end else begin
                    mem_rd_d = in_run;
                end
            end
            ST_WAIT: begin
                ir_d    = in_instruction;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
                // Enables are prepared here so they are registered for the EXECUTE cycle.
                case (opcode_s)
                    OP_MOV: begin
                        rd_en_d = 1'b1;
                        wr_en_d = 1'b1;
                    end
                    OP_LDI: begin
                        imm_en_d = 1'b1;
                        wr_en_d  = 1'b1;
                    end
                    OP_LDIND: begin
                        rd_en_d  = 1'b1;
                        ind_en_d = 1'b1;
                        wr_en_d  = 1'b1;
                    end
                    OP_ADD: begin
                        alu_en_d = 1'b1;
                        wr_en_d  = 1'b1;
                    end
                    OP_SUB: begin
                        alu_en_d = 1'b1;
                        alu_op_d = 1'b1;
                        wr_en_d  = 1'b1;
                    end
                    OP_NOP, OP_JMP, OP_JZ, OP_HALT: begin
                        wr_en_d = 1'b0;
                    end
                    default: begin
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_EXECUTE: begin
                if ((opcode_s == OP_JMP) || ((opcode_s == OP_JZ) && in_zero_flag)) begin
                    pc_d = jump_target_s;
                end else begin
                    pc_d = pc_inc_s;
                end
                if (opcode_s == OP_HALT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d  = ST_FETCH;
                    mem_rd_d = in_run;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State, PC, instruction register and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            mem_rd_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            ind_en_q  <= 1'b0;
            alu_en_q  <= 1'b0;
            alu_op_q  <= 1'b0;
            imm_en_q  <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mem_rd_q  <= mem_rd_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            ind_en_q  <= ind_en_d;
            alu_en_q  <= alu_en_d;
            alu_op_q  <= alu_op_d;
            imm_en_q  <= imm_en_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    assign out_pc               = pc_q;
    assign out_mem_read_en      = mem_rd_q;
    assign out_read_en          = rd_en_q;
    assign out_write_en         = wr_en_q;
    assign out_rx_selector      = ir_q[10:8];
    assign out_ry_selector      = ir_q[7:5];
    assign out_indirect_mode_en = ind_en_q;
    assign out_alu_en           = alu_en_q;
    assign out_alu_op           = alu_op_q;
    assign out_imm_en           = imm_en_q;
    assign out_imm_data         = ir_q[7:0];
    assign out_halted           = halted_q;
    assign out_illegal          = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer: an instruction-level reference model
// predicts every output each cycle, with hand-computed checkpoints on top.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_run;
    logic [15:0] in_instruction;
    logic        in_zero_flag;
    logic [7:0]  out_pc;
    logic        out_mem_read_en, out_read_en, out_write_en;
    logic [2:0]  out_rx_selector, out_ry_selector;
    logic        out_indirect_mode_en, out_alu_en, out_alu_op, out_imm_en;
    logic [7:0]  out_imm_data;
    logic        out_halted, out_illegal;

    always #5 clk = ~clk;

    control_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .in_run(in_run), .in_instruction(in_instruction),
        .in_zero_flag(in_zero_flag), .out_pc(out_pc), .out_mem_read_en(out_mem_read_en),
        .out_read_en(out_read_en), .out_write_en(out_write_en),
        .out_rx_selector(out_rx_selector), .out_ry_selector(out_ry_selector),
        .out_indirect_mode_en(out_indirect_mode_en), .out_alu_en(out_alu_en),
        .out_alu_op(out_alu_op), .out_imm_en(out_imm_en), .out_imm_data(out_imm_data),
        .out_halted(out_halted), .out_illegal(out_illegal)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];
    // Reference model: age of the in-flight instruction (0 idle, 1 read strobe,
    // 2 data returning, 3 decode, 4 execute), architectural PC and instruction.
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    int          m_age;
    bit          m_halted;
    bit          pend;
    logic [7:0]  pend_addr;
    bit          cur_run, cur_zero;
    logic [15:0] cur_instr;
    int          run_ctl, zero_ctl;
    bit          found;
    logic [7:0]  saved_pc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_ir = 16'h0000; m_age = 0; m_halted = 1'b0; pend = 1'b0;
    endtask

    task automatic model_step(input bit run, input bit zero, input logic [15:0] instr);
        logic [4:0] op;
        op = m_ir[15:11];
        if (!m_halted) begin
            case (m_age)
                0: m_age = run ? 1 : 0;
                1: m_age = 2;
                2: begin m_ir = instr; m_age = 3; end
                3: m_age = 4;
                default: begin
                    if (op == 5'd6 || (op == 5'd7 && zero)) m_pc = m_ir[7:0];
                    else m_pc = m_pc + 8'd1;
                    if (op == 5'd31) begin m_halted = 1'b1; m_age = 0; end
                    else m_age = run ? 1 : 0;
                end
            endcase
        end
    endtask

    task automatic compare();
        logic [4:0] op;
        bit ex, wr, ill;
        op  = m_ir[15:11];
        ex  = !m_halted && (m_age == 4);
        wr  = (op == 5'd1 || op == 5'd2 || op == 5'd3 || op == 5'd4 || op == 5'd5);
        ill = !(op <= 5'd7 || op == 5'd31);
        chk("pc",       16'(out_pc),               16'(m_pc));
        chk("mem_rd",   16'(out_mem_read_en),      16'(!m_halted && m_age == 1));
        chk("read_en",  16'(out_read_en),          16'(ex && (op == 5'd1 || op == 5'd3)));
        chk("write_en", 16'(out_write_en),         16'(ex && wr));
        chk("indirect", 16'(out_indirect_mode_en), 16'(ex && op == 5'd3));
        chk("imm_en",   16'(out_imm_en),           16'(ex && op == 5'd2));
        chk("alu_en",   16'(out_alu_en),           16'(ex && (op == 5'd4 || op == 5'd5)));
        chk("alu_op",   16'(out_alu_op),           16'(ex && op == 5'd5));
        chk("illegal",  16'(out_illegal),          16'(ex && ill));
        chk("halted",   16'(out_halted),           16'(m_halted));
        chk("bus_excl", 16'($countones({out_read_en, out_imm_en, out_alu_en}) <= 1), 16'd1);
        if (!m_halted && (m_age == 3 || m_age == 4)) begin
            chk("rx_sel",   16'(out_rx_selector), 16'(m_ir[10:8]));
            chk("ry_sel",   16'(out_ry_selector), 16'(m_ir[7:5]));
            chk("imm_data", 16'(out_imm_data),    16'(m_ir[7:0]));
        end
    endtask

    // One clock: advance model with last cycle's inputs, compare, choose next inputs.
    task automatic tick();
        @(posedge clk); #1;
        model_step(cur_run, cur_zero, cur_instr);
        compare();
        if (pend) cur_instr = mem[pend_addr];
        else cur_instr = 16'($urandom);
        pend = !m_halted && (m_age == 1);
        pend_addr = m_pc;
        case (run_ctl)
            0: cur_run = 1'b0;
            1: cur_run = 1'b1;
            default: cur_run = ($urandom_range(99, 0) < 80);
        endcase
        case (zero_ctl)
            2: cur_zero = (m_pc < 8'h10);
            default: cur_zero = 1'($urandom);
        endcase
        in_run = cur_run; in_zero_flag = cur_zero; in_instruction = cur_instr;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [4:0] op;
        int r;
        r = $urandom_range(9, 0);
        if (r <= 7) op = 5'(r);
        else op = 5'($urandom_range(30, 8));
        return {op, 11'($urandom)};
    endfunction

    initial begin
        rst_n = 1'b0; in_run = 1'b0; in_zero_flag = 1'b0; in_instruction = 16'h0000;
        cur_run = 1'b0; cur_zero = 1'b0; cur_instr = 16'h0000; run_ctl = 0; zero_ctl = 2;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 16'(out_pc), 16'h0000);
        chk("rst_mem_rd", 16'(out_mem_read_en), 16'h0000);
        chk("rst_write_en", 16'(out_write_en), 16'h0000);
        chk("rst_halted", 16'(out_halted), 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_mem_rd", 16'(out_mem_read_en), 16'h0000);
            chk("idle_pc", 16'(out_pc), 16'h0000);
        end

        // Directed program: LDI r1,5; LDI r2,3; ADD r1,r2; LDIND r0,[r2]; JZ 0x10 ...
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        mem[0] = 16'h1105; mem[1] = 16'h1203; mem[2] = 16'h2140; mem[3] = 16'h1840;
        mem[4] = 16'h3810; mem[8'h10] = 16'h3820; mem[8'h11] = 16'h5000;
        mem[8'h12] = 16'h30FF; mem[8'hFF] = 16'h0000;
        run_ctl = 1; cur_run = 1'b1; in_run = 1'b1;
        for (int c = 1; c <= 37; c++) begin
            tick();
            case (c)
                4:  begin chk("c4_wr", 16'(out_write_en), 16'd1); chk("c4_imm", 16'(out_imm_en), 16'd1); end
                5:  chk("c5_wr", 16'(out_write_en), 16'd0);
                8:  chk("c8_wr", 16'(out_write_en), 16'd1);
                12: begin
                    chk("add_wr", 16'(out_write_en), 16'd1);
                    chk("add_alu_en", 16'(out_alu_en), 16'd1);
                    chk("add_alu_op", 16'(out_alu_op), 16'd0);
                    chk("add_rx", 16'(out_rx_selector), 16'd1);
                    chk("add_ry", 16'(out_ry_selector), 16'd2);
                end
                13: chk("pc_after_add", 16'(out_pc), 16'h0003);
                16: begin
                    chk("ldind_rd", 16'(out_read_en), 16'd1);
                    chk("ldind_ind", 16'(out_indirect_mode_en), 16'd1);
                    chk("ldind_wr", 16'(out_write_en), 16'd1);
                    chk("ldind_ry", 16'(out_ry_selector), 16'd2);
                    chk("ldind_imm", 16'(out_imm_en), 16'd0);
                end
                21: chk("jz_taken_pc", 16'(out_pc), 16'h0010);
                25: chk("jz_not_taken_pc", 16'(out_pc), 16'h0011);
                28: begin chk("ill_pulse", 16'(out_illegal), 16'd1); chk("ill_wr", 16'(out_write_en), 16'd0); end
                29: begin chk("ill_once", 16'(out_illegal), 16'd0); chk("ill_pc", 16'(out_pc), 16'h0012); end
                33: chk("jmp_pc", 16'(out_pc), 16'h00FF);
                37: chk("wrap_pc", 16'(out_pc), 16'h0000);
                default: ;
            endcase
        end

        // Random programs with random run and zero flag.
        for (int a = 0; a < 256; a++) mem[a] = rand_instr();
        run_ctl = 2; zero_ctl = 3;
        repeat (600) tick();

        // in_run drops during DECODE: the instruction still executes, then park.
        for (int a = 0; a < 256; a++) mem[a] = 16'h1155;
        run_ctl = 1;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (!m_halted && m_age == 3) found = 1'b1;
        end
        chk("find_decode", 16'(found), 16'd1);
        saved_pc = m_pc;
        run_ctl = 0; cur_run = 1'b0; in_run = 1'b0;
        tick();
        chk("drop_exec_wr", 16'(out_write_en), 16'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("parked_mem_rd", 16'(out_mem_read_en), 16'd0);
            chk("parked_pc", 16'(out_pc), 16'(saved_pc + 8'd1));
        end
        run_ctl = 1; cur_run = 1'b1; in_run = 1'b1;
        tick();
        chk("resume_mem_rd", 16'(out_mem_read_en), 16'd1);
        chk("resume_pc", 16'(out_pc), 16'(saved_pc + 8'd1));

        // Reset in the middle of an LDI EXECUTE drops enables without a clock edge.
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (!m_halted && m_age == 4) found = 1'b1;
        end
        chk("find_exec", 16'(found), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_wr", 16'(out_write_en), 16'd0);
        chk("async_imm", 16'(out_imm_en), 16'd0);
        chk("async_pc", 16'(out_pc), 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        // HALT is sticky with the PC frozen until reset.
        for (int a = 0; a < 256; a++) mem[a] = 16'hF800;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (m_halted) found = 1'b1;
        end
        chk("reach_halt", 16'(found), 16'd1);
        saved_pc = m_pc;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_sticky", 16'(out_halted), 16'd1);
            chk("halt_pc", 16'(out_pc), 16'(saved_pc));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("halt_rst_clear", 16'(out_halted), 16'd0);
        chk("halt_rst_pc", 16'(out_pc), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit DRFA datapath.
- Sits directly upstream of the register bank and drives all of its control inputs: read_en, write_en, rx/ry selectors and indirect mode.
- Also drives the immediate source and the ALU enable onto the shared 8-bit bus, and owns the program counter.

Parameters:
- PC_WIDTH, 8, program counter and program memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_run  input  1  level; high lets the sequencer start new instructions.
- in_instruction  input  16  program memory read data; valid one cycle after out_mem_read_en.
- in_zero_flag  input  1  ALU zero flag, sampled in EXECUTE.
- out_pc  output  PC_WIDTH  program memory address.
- out_mem_read_en  output  1  program memory read strobe.
- out_read_en  output  1  to register bank read_en.
- out_write_en  output  1  to register bank write_en.
- out_rx_selector  output  3  instruction field [10:8].
- out_ry_selector  output  3  instruction field [7:5].
- out_indirect_mode_en  output  1  to register bank indirect mode.
- out_alu_en  output  1  ALU drives result onto bus.
- out_alu_op  output  1  0 = ADD, 1 = SUB.
- out_imm_en  output  1  sequencer drives out_imm_data onto bus.
- out_imm_data  output  8  instruction field [7:0].
- out_halted  output  1  high while in HALT.
- out_illegal  output  1  one-cycle pulse on undefined opcode.

Behaviour:
- Reset (async, rst_n low): state FETCH; PC = RESET_PC; instruction register = 0; out_halted = 0; every enable/strobe = 0. Outputs hold these values while rst_n is low and after release until the first clk edge.
- Instruction format: opcode [15:11], rx [10:8], ry [7:5], imm8 [7:0].
- Opcodes:
  - 00000 NOP.
  - 00001 MOV: rx <- ry.
  - 00010 LDI: rx <- imm8.
  - 00011 LDIND: rx <- reg[reg[ry]].
  - 00100 ADD: rx <- rx + ry.
  - 00101 SUB: rx <- rx - ry.
  - 00110 JMP: pc <- imm8.
  - 00111 JZ: pc <- imm8 if zero flag set.
  - 11111 HALT.
  - Any other code: treated as NOP plus an out_illegal pulse.
- State FETCH:
  - If in_run = 1, assert out_mem_read_en and go to WAIT.
  - If in_run = 0, stay in FETCH with all outputs idle.
- State WAIT: latch in_instruction into the instruction register at the end of the cycle, then go to DECODE.
- State DECODE:
  - Selectors and out_imm_data are driven from the instruction register; they remain stable from here through EXECUTE.
  - No enables are asserted.
  - Go to EXECUTE.
- State EXECUTE (exactly one cycle):
  - MOV: out_read_en = 1 and out_write_en = 1.
  - LDIND: out_read_en = 1, out_indirect_mode_en = 1 and out_write_en = 1.
  - LDI: out_imm_en = 1 and out_write_en = 1.
  - ADD/SUB: out_alu_en = 1, out_alu_op set, out_write_en = 1.
  - The register bank captures the bus at the closing clk edge.
  - PC update: pc <- imm8 for JMP, and for JZ when in_zero_flag = 1; otherwise pc <- pc + 1, wrapping 255 -> 0.
  - Undefined opcode: out_illegal = 1 this cycle only.
  - Next state FETCH, or HALT for opcode 11111.
- State HALT: sticky; all enables 0, out_halted = 1, PC frozen. Only rst_n exits HALT.
- Bus exclusivity: at most one of out_read_en, out_imm_en, out_alu_en is high in any cycle. This is an invariant.
- Latency: 4 cycles per instruction with in_run held high. A write to rx is visible to the next instruction's DECODE.
- in_run dropping mid-instruction: the current instruction completes; the sequencer parks in FETCH.
- Reset asserted mid-EXECUTE: enables drop immediately (async); PC returns to RESET_PC.
- JZ samples in_zero_flag only in EXECUTE. Values at other times are ignored.

Test Plan:
- Reset with in_run = 0 for 5 cycles -> out_pc = 0, all enables 0, state stays FETCH, no out_mem_read_en.
- Program LDI r1,0x05; LDI r2,0x03; ADD r1,r2 -> write_en pulses at cycles 4, 8 and 12. During ADD EXECUTE: alu_en = 1, alu_op = 0, rx_selector = 1, ry_selector = 2. out_pc reaches 3.
- LDIND r0,[r2], instruction 0x1840 -> EXECUTE has read_en = 1, indirect_mode_en = 1, write_en = 1, ry_selector = 2, imm_en = 0.
- JZ 0x10 with in_zero_flag = 1 -> next out_pc = 0x10. With in_zero_flag = 0 -> out_pc = old + 1. JMP from pc = 0xFF without jump path: NOP at 0xFF -> out_pc wraps to 0x00.
- Opcode 01010 -> out_illegal high for exactly 1 cycle, no write_en, PC + 1. HALT 0xF800 -> out_halted = 1, PC frozen for 20 cycles. rst_n low -> halted clears asynchronously.
- in_run drops during DECODE -> EXECUTE still occurs, then the sequencer idles in FETCH. Re-raising in_run -> fetch resumes at the next PC.
